prog_clk_divider: RTL and testbench

//   Multi-channel programmable clock divider / tick generator. Each of NUM_CH

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_channel.sv | 89 ++++++++
 rtl/prog_clk_divider.sv | 48 ++++
 tb/tb_prog_clk_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

   localparam int CNT_W_DEF       = 27;
   localparam int DEFAULT_DIV_DEF = 50_000_000;
   localparam int EFF_W           = 32;

   // A divisor of zero behaves like one: a tick on every cycle.
   function automatic logic [EFF_W-1:0] eff_div(input logic [EFF_W-1:0] d);
      return (d == '0) ? EFF_W'(1) : d;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/pending divisor, registered tick
// and square-wave output.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_div,
   output logic             tick,
   output logic             sq
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   logic [CNT_W-1:0] wr_eff;
   logic             wrap;

   assign wr_eff = CNT_W'(eff_div(EFF_W'(wr_div)));
   assign wrap   = (cnt_q == (div_q - CNT_W'(1)));

   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tick_d     = 1'b0;
      sq_d       = sq_q;

      if (restart) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
         end
      end else if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (pend_vld_q) begin
               div_d      = pend_q;
               pend_vld_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Evaluated after any reload so a write on a boundary targets the next period.
      if (wr_en) begin
         pend_d     = wr_eff;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         div_q      <= CNT_W'(DEFAULT_DIV);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         tick_q     <= 1'b0;
         sq_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable tick / square-wave generator with per-channel
// runtime divisors that switch only at period boundaries.
module prog_clk_divider
   import clk_div_pkg::*;
#(
   parameter int  NUM_CH      = 4,
   parameter int  CNT_W       = CNT_W_DEF,
   parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              restart,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq_out
);

   logic [NUM_CH-1:0] ch_we;

   // Indices past the last channel match nothing, so such writes are dropped.
   always_comb begin
      ch_we = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .restart (restart),
         .wr_en   (ch_we[g]),
         .wr_div  (cfg_div),
         .tick    (tick[g]),
         .sq      (sq_out[g])
      );
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Scoreboard bench for prog_clk_divider: directed phases push hand-computed tick
// cycles and snapshots; an independent monitor compares at every falling edge.
module tb_prog_clk_divider;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   typedef struct {
      int   cyc;
      logic sq;
   } tick_exp_t;

   typedef struct {
      int          cyc;
      logic [3:0]  tk;
      logic [3:0]  sq;
   } snap_exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              restart = 1'b0;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq_out;

   int        cyc = 0;
   int        base = 0;
   int        total = 0;
   int        bad = 0;
   logic      done = 1'b0;
   logic      mon_fin = 1'b0;
   tick_exp_t exp_q [NUM_CH][$];
   snap_exp_t snap_q [$];

   prog_clk_divider #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .restart (restart),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .tick    (tick),
      .sq_out  (sq_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic goto(input int t);
      while (cyc < base + t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_tick(input int ch, input int t, input logic s);
      tick_exp_t e;
      e.cyc = base + t;
      e.sq  = s;
      exp_q[ch].push_back(e);
   endtask

   task automatic push_run(input int ch, input int first, input int step, input int n, input logic s0);
      for (int k = 0; k < n; k++) begin
         push_tick(ch, first + k * step, s0 ^ k[0]);
      end
   endtask

   task automatic push_snap(input int t, input logic [3:0] tk, input logic [3:0] sq);
      snap_exp_t e;
      e.cyc = base + t;
      e.tk  = tk;
      e.sq  = sq;
      snap_q.push_back(e);
   endtask

   task automatic cfg_write(input int t, input int ch, input int d);
      goto(t - 1);
      cfg_we  = 1'b1;
      cfg_ch  = 2'(ch);
      cfg_div = 8'(d);
      goto(t);
      cfg_we  = 1'b0;
   endtask

   // Monitor: owns all comparison counters.
   initial begin
      tick_exp_t te;
      snap_exp_t se;
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            while (exp_q[ch].size() > 0 && exp_q[ch][0].cyc < cyc) begin
               te = exp_q[ch].pop_front();
               total++;
               bad++;
               $display("FAIL tick_missing ch%0d cyc=%0d: got tick=0 want tick=1", ch, te.cyc);
            end
            if (exp_q[ch].size() > 0 && exp_q[ch][0].cyc == cyc) begin
               te = exp_q[ch].pop_front();
               total++;
               if (tick[ch] !== 1'b1 || sq_out[ch] !== te.sq) begin
                  bad++;
                  $display("FAIL tick_chk ch%0d cyc=%0d: got tick=%b sq=%b want tick=1 sq=%b",
                           ch, cyc, tick[ch], sq_out[ch], te.sq);
               end
            end else if (tick[ch] !== 1'b0) begin
               total++;
               bad++;
               $display("FAIL tick_unexpected ch%0d cyc=%0d: got tick=%b want tick=0", ch, cyc, tick[ch]);
            end
         end
         while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            se = snap_q.pop_front();
            total++;
            if (se.cyc != cyc || tick !== se.tk || sq_out !== se.sq) begin
               bad++;
               $display("FAIL snapshot cyc=%0d (at %0d): got tick=%b sq=%b want tick=%b sq=%b",
                        se.cyc, cyc, tick, sq_out, se.tk, se.sq);
            end
         end
         if (done && !mon_fin) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               while (exp_q[ch].size() > 0) begin
                  te = exp_q[ch].pop_front();
                  total++;
                  bad++;
                  $display("FAIL tick_never_seen ch%0d cyc=%0d: got none want tick=1", ch, te.cyc);
               end
            end
            while (snap_q.size() > 0) begin
               se = snap_q.pop_front();
               total++;
               bad++;
               $display("FAIL snapshot_never_taken cyc=%0d: got none want tick=%b sq=%b", se.cyc, se.tk, se.sq);
            end
            mon_fin = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, reached without any clock edge.
      base = 0;
      push_snap(1, 4'h0, 4'h0);
      #2 rst = 1'b0;
      goto(3);

      // Phase A: default period, divisor writes, divisor 0, last-write-wins,
      // write on a wrap edge.
      base = cyc;
      rst  = 1'b1;
      en   = 1'b1;
      push_run(0, 4, 4, 4, 1'b1);
      push_tick(0, 21, 1'b1);
      push_run(1, 4, 4, 2, 1'b1);
      push_run(1, 11, 3, 4, 1'b1);
      push_run(2, 4, 4, 3, 1'b1);
      push_run(2, 13, 1, 9, 1'b0);
      push_run(3, 4, 4, 4, 1'b1);
      push_run(3, 18, 2, 2, 1'b1);
      push_snap(22, 4'h0, 4'h0);
      cfg_write(6, 1, 3);
      cfg_write(10, 2, 0);
      cfg_write(12, 0, 5);
      cfg_write(13, 3, 7);
      cfg_write(14, 3, 2);
      goto(22);
      #1 rst = 1'b0;
      goto(25);

      // Phase B/C: en freeze, restart on a wrap with pending divisor and a
      // same-cycle write, restart mid-period, async reset mid-count.
      base = cyc;
      rst  = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         push_tick(ch, 4, 1'b1);
         push_run(ch, 13, 4, 2, 1'b0);
      end
      push_tick(0, 27, 1'b1);
      push_run(0, 34, 6, 2, 1'b1);
      push_run(1, 25, 2, 2, 1'b1);
      push_run(1, 30, 2, 6, 1'b1);
      for (int ch = 2; ch < NUM_CH; ch++) begin
         push_tick(ch, 25, 1'b1);
         push_run(ch, 32, 4, 3, 1'b1);
      end
      push_snap(21, 4'h0, 4'h0);
      push_snap(28, 4'h0, 4'h0);
      push_snap(42, 4'h0, 4'h0);
      goto(5);
      en = 1'b0;
      goto(10);
      en = 1'b1;
      cfg_write(18, 0, 6);
      goto(20);
      restart = 1'b1;
      cfg_we  = 1'b1;
      cfg_ch  = 2'd1;
      cfg_div = 8'd2;
      goto(21);
      restart = 1'b0;
      cfg_we  = 1'b0;
      goto(27);
      restart = 1'b1;
      goto(28);
      restart = 1'b0;
      goto(42);
      #1 rst = 1'b0;
      goto(45);

      // Phase D: timing after reset matches the power-up timing.
      base = cyc;
      rst  = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         push_run(ch, 4, 4, 3, 1'b1);
      end
      goto(14);
      done = 1'b1;
      for (int i = 0; i < 10 && !mon_fin; i++) @(posedge clk);
      if (!mon_fin) begin
         $display("FAIL monitor_stall: got no final drain want drain");
         $fatal(1, "monitor stall");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
